multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle sequencing controller for the 16-bit accumulator-style CPU. It replaces single-cycle combinational decode with a state machine. The machine fetches over a ready/valid instruction port, decodes, executes and writes back. It stalls on data-memory wait states and tracks a nested subroutine return stack of configurable depth. It sits between the instruction/data memories and the existing datapath (ALU, register file, PC/LR muxes) and drives the same select encodings the datapath already decodes.

## Interface
- INST_W, 16: instruction width; ≥16. opcode = inst[INST_W-1:INST_W-4], brx = inst[INST_W-5].
- LR_DEPTH, 4: return-address stack entries; ≥1.
- PW, $clog2(LR_DEPTH+1): width of lr_ptr (derived, not overridable).

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- inst  in  INST_W  instruction word, valid when inst_ready=1.
- inst_ready  in  1  instruction memory has data for the current inst_req.
- mem_ready  in  1  data memory has completed the current mem_req.
- br_mux  in  1  Z or N flag, as selected by br_sel.
- inst_req  out  1  fetch request.
- ir_en  out  1  datapath latches inst (fields imm/ea/ra).
- alu_op  out  4  ALU operation.
- pc_sel  out  2  00 PC+2, 01 LR, 10 ea.
- pc_en  out  1  PC update strobe.
- wb_sel  out  2  00 result, 01 in.port, 10 imm, 11 MDR.
- wb_demux_sel  out  1  0 R[ra], 1 out.port.
- br_sel  out  1  0 Z, 1 N.
- reg_en  out  1  write strobe (R[ra] or out.port, per wb_demux_sel).
- mem_req, mem_we  out  1,1  data access request / write.
- mdr_en  out  1  datapath latches memory read data.
- lr_push, lr_pop  out  1,1  return stack push (PC+2) / pop.
- lr_ptr  out  PW  current stack occupancy.
- fault  out  1  sticky stack over/underflow.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT. Outputs decode from state and the internal IR. All outputs are 0 unless listed below.
- IDLE: go to FETCH on the next clock.
- FETCH: inst_req=1. When inst_ready=1: ir_en=1, latch IR, go to DECODE. Otherwise hold with inst_req kept high.
- DECODE: one cycle, then EXEC.
- EXEC: alu_op = opcode for 0001–1000, else 0000. br_sel = brx for opcode 1010, else 0. Decisions made here:
  - 1010 registers taken = br_mux.
  - 1011 with lr_ptr==LR_DEPTH goes to FAULT.
  - 1100 with lr_ptr==0 goes to FAULT.
  - 1101 and 1110 go to MEM.
  - All other opcodes go to WB.
- MEM: mem_req=1. mem_we=1 for 1110. alu_op is 0000.
  - When mem_ready=1: mdr_en=1 if opcode is 1101, then go to WB.
  - Otherwise hold.
- WB: one cycle. pc_en=1, then go to FETCH. alu_op and br_sel keep their EXEC values. Per opcode:
  - 0000: pc_sel=00.
  - 0001–0101, 1000: reg_en=1, wb_sel=00.
  - 0110: reg_en=1, wb_demux_sel=1.
  - 0111: reg_en=1, wb_sel=01.
  - 1001: pc_sel=10.
  - 1010: pc_sel = 10 if taken, else 00.
  - 1011: pc_sel=10, lr_push=1, lr_ptr+1.
  - 1100: pc_sel=01, lr_pop=1, lr_ptr-1.
  - 1101: reg_en=1, wb_sel=11.
  - 1110: no write.
  - 1111: reg_en=1, wb_sel=10.
- FAULT: fault=1, all other outputs 0. No exit except reset.
- lr_ptr changes only in WB of 1011/1100, so it never exceeds LR_DEPTH or goes below 0.

## Timing
- Reset (async assert, released synchronously by clk):
  - state=IDLE, IR=0, taken=0, lr_ptr=0.
  - All outputs are 0, including fault.
  - inst_req rises in the 2nd cycle after rst_n deasserts.
- Latency with zero wait states:
  - Non-memory instructions take 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE take 5 cycles.
  - Each cycle with inst_ready=0 or mem_ready=0 adds 1 cycle.
- Handshakes: inst_req and mem_req stay high until sampled with their ready. A ready seen while its req is low is ignored.
- br_mux is sampled only on the EXEC clock edge. Flag changes afterwards do not affect the branch.
- Strobes are exactly one cycle each: ir_en, mdr_en, pc_en, reg_en, lr_push, lr_pop.
- Reset asserted in any state, including during a MEM wait, returns to IDLE immediately. The abandoned access is dropped (mem_req falls asynchronously).

## Test plan
- Reset, then ADD (0x1xxx) with inst_ready tied to 1 -> inst_req in cycle 2; ir_en at cycle 2; reg_en=1 and pc_en=1 with wb_sel=00 and alu_op=0001 at cycle 5; next inst_req at cycle 6.
- LOAD (0xDxxx) with mem_ready low for 2 cycles -> mem_req high 3 cycles; mdr_en on the 3rd; WB has wb_sel=11 and reg_en=1; total 7 cycles.
- BR.N (0xA800) -> br_sel=1 in EXEC. With br_mux=1 at EXEC, then toggled to 0 in WB, WB still has pc_sel=10. Repeat with br_mux=0 -> pc_sel=00.
- LR_DEPTH=4: five nested BR.SUB (0xBxxx) -> lr_push on the first four with lr_ptr stepping 1..4; the fifth reaches FAULT with fault=1, no pc_en and no push. Reset clears fault and lr_ptr to 0.
- RET (0xC000) directly after reset -> FAULT, no lr_pop. After BR.SUB then RET -> pc_sel=01, lr_pop=1, lr_ptr back to 0.
- Assert rst_n=0 mid-MEM with mem_ready=0 -> mem_req drops without a clock; on release, state is IDLE, lr_ptr=0, and a new fetch starts after 1 cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle sequencer for the 16-bit accumulator CPU. It fetches over a
// ready/valid port, then decodes, executes, optionally waits on data memory,
// and writes back. It drives the datapath select encodings and tracks how
// many entries the return-address stack holds.
module multicycle_controller #(
  parameter  int INST_W   = 16,
  parameter  int LR_DEPTH = 4,
  localparam int PW       = $clog2(LR_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_ready,
  input  logic              mem_ready,
  input  logic              br_mux,
  output logic              inst_req,
  output logic              ir_en,
  output logic [3:0]        alu_op,
  output logic [1:0]        pc_sel,
  output logic              pc_en,
  output logic [1:0]        wb_sel,
  output logic              wb_demux_sel,
  output logic              br_sel,
  output logic              reg_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mdr_en,
  output logic              lr_push,
  output logic              lr_pop,
  output logic [PW-1:0]     lr_ptr,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_BR    = 4'h9;
  localparam logic [3:0] OP_BRC   = 4'hA;
  localparam logic [3:0] OP_CALL  = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hC;
  localparam logic [3:0] OP_LOAD  = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_LDI   = 4'hF;

  localparam logic [PW-1:0] LR_FULL = PW'(LR_DEPTH);

  state_e        state_q, state_d;
  // Only the control fields of the instruction are kept: {opcode, brx}.
  // The datapath latches the operand fields itself on ir_en.
  logic [4:0]    ir_q, ir_d;
  logic          taken_q, taken_d;
  logic [PW-1:0] lr_ptr_q, lr_ptr_d;

  logic [3:0] opcode;
  logic       brx;
  logic       is_alu;
  logic [3:0] alu_op_x;
  logic       br_sel_x;

  assign opcode = ir_q[4:1];
  assign brx    = ir_q[0];
  assign is_alu = (opcode >= 4'h1) && (opcode <= 4'h8);

  // ALU op and branch-flag select are driven identically in EXEC and WB.
  assign alu_op_x = is_alu ? opcode : 4'h0;
  assign br_sel_x = (opcode == OP_BRC) && brx;

  // Operand bits are consumed by the datapath, not by the controller.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[INST_W-6:0];

  assign lr_ptr = lr_ptr_q;

  // State register and controller bookkeeping (IR, branch decision, stack depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      taken_q  <= 1'b0;
      lr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values; blocking would create order-dependent races.
      state_q  <= state_d;
      ir_q     <= ir_d;
      taken_q  <= taken_d;
      lr_ptr_q <= lr_ptr_d;
    end
  end

  // Next-state logic: handshake stalls, EXEC decisions and stack bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    ir_d     = ir_q;
    taken_d  = taken_q;
    lr_ptr_d = lr_ptr_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (inst_ready) begin
          ir_d    = inst[INST_W-1 -: 5];
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_BRC: begin
            taken_d = br_mux;
            state_d = S_WB;
          end
          OP_CALL:           state_d = (lr_ptr_q == LR_FULL) ? S_FAULT : S_WB;
          OP_RET:            state_d = (lr_ptr_q == '0) ? S_FAULT : S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
        // EXEC already vetoed overflow/underflow, so these cannot wrap.
        if (opcode == OP_CALL) lr_ptr_d = lr_ptr_q + PW'(1);
        else if (opcode == OP_RET) lr_ptr_d = lr_ptr_q - PW'(1);
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and the held instruction fields.
  always_comb begin
    inst_req     = 1'b0;
    ir_en        = 1'b0;
    alu_op       = 4'h0;
    pc_sel       = 2'b00;
    pc_en        = 1'b0;
    wb_sel       = 2'b00;
    wb_demux_sel = 1'b0;
    br_sel       = 1'b0;
    reg_en       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mdr_en       = 1'b0;
    lr_push      = 1'b0;
    lr_pop       = 1'b0;
    fault        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        inst_req = 1'b1;
        ir_en    = inst_ready;
      end
      S_EXEC: begin
        alu_op = alu_op_x;
        br_sel = br_sel_x;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        mdr_en  = mem_ready && (opcode == OP_LOAD);
      end
      S_WB: begin
        alu_op = alu_op_x;
        br_sel = br_sel_x;
        pc_en  = 1'b1;
        case (opcode)
          OP_NOP: pc_sel = 2'b00;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: begin
            reg_en = 1'b1;
            wb_sel = 2'b00;
          end
          OP_OUT: begin
            reg_en       = 1'b1;
            wb_demux_sel = 1'b1;
          end
          OP_IN: begin
            reg_en = 1'b1;
            wb_sel = 2'b01;
          end
          OP_BR:  pc_sel = 2'b10;
          OP_BRC: pc_sel = taken_q ? 2'b10 : 2'b00;
          OP_CALL: begin
            pc_sel  = 2'b10;
            lr_push = 1'b1;
          end
          OP_RET: begin
            pc_sel = 2'b01;
            lr_pop = 1'b1;
          end
          OP_LOAD: begin
            reg_en = 1'b1;
            wb_sel = 2'b11;
          end
          OP_STORE: pc_sel = 2'b00;
          OP_LDI: begin
            reg_en = 1'b1;
            wb_sel = 2'b10;
          end
          default: pc_sel = 2'b00;
        endcase
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller (INST_W=16, LR_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. All control outputs except lr_ptr are packed into one
// 20-bit vector and compared against hand-built expected vectors.
module tb_multicycle_controller;

  localparam int PW = 3;

  logic          clk;
  logic          rst_n;
  logic [15:0]   inst;
  logic          inst_ready;
  logic          mem_ready;
  logic          br_mux;
  logic          inst_req, ir_en, pc_en, wb_demux_sel, br_sel, reg_en;
  logic          mem_req, mem_we, mdr_en, lr_push, lr_pop, fault;
  logic [3:0]    alu_op;
  logic [1:0]    pc_sel, wb_sel;
  logic [PW-1:0] lr_ptr;

  multicycle_controller #(.INST_W(16), .LR_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .mem_ready    (mem_ready),
    .br_mux       (br_mux),
    .inst_req     (inst_req),
    .ir_en        (ir_en),
    .alu_op       (alu_op),
    .pc_sel       (pc_sel),
    .pc_en        (pc_en),
    .wb_sel       (wb_sel),
    .wb_demux_sel (wb_demux_sel),
    .br_sel       (br_sel),
    .reg_en       (reg_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mdr_en       (mdr_en),
    .lr_push      (lr_push),
    .lr_pop       (lr_pop),
    .lr_ptr       (lr_ptr),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit layout of the packed observation vector.
  localparam logic [19:0] INST_REQ = 20'h80000;
  localparam logic [19:0] IR_EN    = 20'h40000;
  localparam logic [19:0] PC_EN    = 20'h00800;
  localparam logic [19:0] WB_DMX   = 20'h00100;
  localparam logic [19:0] BR_SEL   = 20'h00080;
  localparam logic [19:0] REG_EN   = 20'h00040;
  localparam logic [19:0] MEM_REQ  = 20'h00020;
  localparam logic [19:0] MEM_WE   = 20'h00010;
  localparam logic [19:0] MDR_EN   = 20'h00008;
  localparam logic [19:0] LR_PUSH  = 20'h00004;
  localparam logic [19:0] LR_POP   = 20'h00002;
  localparam logic [19:0] FAULT    = 20'h00001;

  function automatic logic [19:0] alu(input logic [3:0] v);
    return {2'b00, v, 14'h0};
  endfunction
  function automatic logic [19:0] pcs(input logic [1:0] v);
    return {6'h0, v, 12'h0};
  endfunction
  function automatic logic [19:0] wbs(input logic [1:0] v);
    return {9'h0, v, 9'h0};
  endfunction

  logic [19:0] obs;
  assign obs = {inst_req, ir_en, alu_op, pc_sel, pc_en, wb_sel, wb_demux_sel,
                br_sel, reg_en, mem_req, mem_we, mdr_en, lr_push, lr_pop, fault};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Sample the current cycle on the falling edge, then move to the start
  // of the next cycle where the caller may change inputs.
  task automatic cycle(input string tag, input logic [19:0] exp);
    @(negedge clk);
    check(tag, {12'h0, obs}, {12'h0, exp});
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously, check the cleared outputs, release after
  // the next edge. The caller is then in cycle 1 (IDLE).
  task automatic do_reset(input string tag);
    rst_n      = 1'b0;
    inst       = '0;
    inst_ready = 1'b0;
    mem_ready  = 1'b0;
    br_mux     = 1'b0;
    #1;
    check({tag, "_out"}, {12'h0, obs}, 32'h0);
    check({tag, "_ptr"}, {29'h0, lr_ptr}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Called at the start of a FETCH cycle; leaves the caller at the start of EXEC.
  task automatic fetch_dec(input string tag, input logic [15:0] instr, input int waits);
    inst       = instr;
    inst_ready = 1'b0;
    repeat (waits) cycle({tag, "_fw"}, INST_REQ);
    inst_ready = 1'b1;
    cycle({tag, "_f"}, INST_REQ | IR_EN);
    inst_ready = 1'b0;
    cycle({tag, "_d"}, 20'h0);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [19:0] ex;
    logic [19:0] wb;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; inst = '0; inst_ready = 1'b0; mem_ready = 1'b0; br_mux = 1'b0;

    tbl.push_back('{16'h0000, 20'h0,       PC_EN});
    tbl.push_back('{16'h3FFF, alu(4'h3),   alu(4'h3) | REG_EN | PC_EN});
    tbl.push_back('{16'h5001, alu(4'h5),   alu(4'h5) | REG_EN | PC_EN});
    tbl.push_back('{16'h6000, alu(4'h6),   alu(4'h6) | REG_EN | WB_DMX | PC_EN});
    tbl.push_back('{16'h7000, alu(4'h7),   alu(4'h7) | REG_EN | wbs(2'b01) | PC_EN});
    tbl.push_back('{16'h8123, alu(4'h8),   alu(4'h8) | REG_EN | PC_EN});
    tbl.push_back('{16'h9ABC, 20'h0,       pcs(2'b10) | PC_EN});
    tbl.push_back('{16'hF0AB, 20'h0,       REG_EN | wbs(2'b10) | PC_EN});

    // Reset then ADD with inst_ready high: inst_req/ir_en in cycle 2, WB in cycle 5.
    do_reset("rst0");
    inst = 16'h1234; inst_ready = 1'b1;
    cycle("add_c1", 20'h0);
    cycle("add_c2", INST_REQ | IR_EN);
    inst_ready = 1'b0;
    cycle("add_c3", 20'h0);
    cycle("add_c4", alu(4'h1));
    cycle("add_c5", alu(4'h1) | REG_EN | PC_EN);

    // LOAD: one fetch wait (cycle 6 shows inst_req), two data wait states.
    fetch_dec("ld", 16'hD123, 1);
    cycle("ld_ex", 20'h0);
    cycle("ld_m1", MEM_REQ);
    cycle("ld_m2", MEM_REQ);
    mem_ready = 1'b1;
    cycle("ld_m3", MEM_REQ | MDR_EN);
    mem_ready = 1'b0;
    cycle("ld_wb", REG_EN | wbs(2'b11) | PC_EN);

    // STORE: mem_ready already high in EXEC is ignored; one MEM cycle.
    fetch_dec("st", 16'hE456, 0);
    mem_ready = 1'b1;
    cycle("st_ex", 20'h0);
    cycle("st_mem", MEM_REQ | MEM_WE);
    mem_ready = 1'b0;
    cycle("st_wb", PC_EN);

    // BR.N taken: flag high at the EXEC edge, dropped during WB.
    fetch_dec("brn_t", 16'hA800, 0);
    br_mux = 1'b1;
    cycle("brn_t_ex", BR_SEL);
    br_mux = 1'b0;
    cycle("brn_t_wb", BR_SEL | pcs(2'b10) | PC_EN);

    // BR.N not taken: flag low at EXEC, raised during WB.
    fetch_dec("brn_n", 16'hA800, 0);
    br_mux = 1'b0;
    cycle("brn_n_ex", BR_SEL);
    br_mux = 1'b1;
    cycle("brn_n_wb", BR_SEL | PC_EN);
    br_mux = 1'b0;

    // BR.Z taken: br_sel stays 0.
    fetch_dec("brz", 16'hA000, 0);
    br_mux = 1'b1;
    cycle("brz_ex", 20'h0);
    br_mux = 1'b0;
    cycle("brz_wb", pcs(2'b10) | PC_EN);

    // Remaining non-memory opcodes.
    foreach (tbl[i]) begin
      fetch_dec($sformatf("op%h", tbl[i].ins[15:12]), tbl[i].ins, 0);
      cycle($sformatf("op%h_ex", tbl[i].ins[15:12]), tbl[i].ex);
      cycle($sformatf("op%h_wb", tbl[i].ins[15:12]), tbl[i].wb);
    end

    // Nested BR.SUB: four pushes, the fifth overflows into FAULT.
    do_reset("lr");
    cycle("lr_idle", 20'h0);
    for (int i = 0; i < 4; i++) begin
      fetch_dec($sformatf("call%0d", i), 16'hB000, 0);
      check($sformatf("call%0d_ptr", i), {29'h0, lr_ptr}, i);
      cycle($sformatf("call%0d_ex", i), 20'h0);
      cycle($sformatf("call%0d_wb", i), pcs(2'b10) | PC_EN | LR_PUSH);
    end
    check("call_ptr_full", {29'h0, lr_ptr}, 32'd4);
    fetch_dec("call4", 16'hB000, 0);
    cycle("call4_ex", 20'h0);
    cycle("call4_flt", FAULT);
    cycle("call4_stick", FAULT);
    do_reset("lr_clr");

    // RET with an empty stack faults without popping.
    cycle("ret0_idle", 20'h0);
    fetch_dec("ret0", 16'hC000, 0);
    cycle("ret0_ex", 20'h0);
    cycle("ret0_flt", FAULT);
    do_reset("ret_clr");

    // BR.SUB then RET returns the stack to empty.
    cycle("ret1_idle", 20'h0);
    fetch_dec("ret1_call", 16'hB010, 0);
    cycle("ret1_call_ex", 20'h0);
    cycle("ret1_call_wb", pcs(2'b10) | PC_EN | LR_PUSH);
    fetch_dec("ret1", 16'hC000, 0);
    check("ret1_ptr", {29'h0, lr_ptr}, 32'd1);
    cycle("ret1_ex", 20'h0);
    cycle("ret1_wb", pcs(2'b01) | PC_EN | LR_POP);
    check("ret1_ptr_after", {29'h0, lr_ptr}, 32'd0);

    // Reset during a MEM wait: mem_req drops without a clock edge.
    fetch_dec("rm_call", 16'hB000, 0);
    cycle("rm_call_ex", 20'h0);
    cycle("rm_call_wb", pcs(2'b10) | PC_EN | LR_PUSH);
    fetch_dec("rm_ld", 16'hD000, 0);
    cycle("rm_ld_ex", 20'h0);
    cycle("rm_ld_m1", MEM_REQ);
    #1;
    check("rm_req_before", {12'h0, obs}, {12'h0, MEM_REQ});
    rst_n = 1'b0;
    #1;
    check("rm_req_drop", {12'h0, obs}, 32'h0);
    check("rm_ptr_clr", {29'h0, lr_ptr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("rm_idle", 20'h0);
    cycle("rm_fetch", INST_REQ);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
